// File: rtl/uart_receiver_if.sv
// Receive-side bundle: line, baud code and enable in; received byte and frame status out.
interface uart_receiver_if;
    logic [2:0] baud_sel;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    modport master (
        output baud_sel, Rx_EN, RxD,
        input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
    );

    modport slave (
        input  baud_sel, Rx_EN, RxD,
        output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
    );
endinterface

// File: rtl/uart_receiver.sv
// 8E1 UART receiver with 16x oversampling; mid-bit sampling, frame evaluated at mid-stop.
module uart_receiver #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic           clk,
    input  logic           reset,
    uart_receiver_if.slave rx
);

    function automatic int unsigned div_for(input int unsigned baud);
        return (CLK_HZ + 8 * baud) / (16 * baud);
    endfunction

    localparam int unsigned DivW = $clog2(div_for(300) + 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d, div_sel;
    logic [DivW-1:0] bcnt_q, bcnt_d;
    logic [3:0]      s_q, s_d;
    logic [2:0]      b_q, b_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            sync1_q, sync2_q, prev_q;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            tick, mid, last;

    always_comb begin
        unique case (rx.baud_sel)
            3'b000: div_sel = DivW'(div_for(300));
            3'b001: div_sel = DivW'(div_for(1200));
            3'b010: div_sel = DivW'(div_for(4800));
            3'b011: div_sel = DivW'(div_for(9600));
            3'b100: div_sel = DivW'(div_for(19200));
            3'b101: div_sel = DivW'(div_for(38400));
            3'b110: div_sel = DivW'(div_for(57600));
            3'b111: div_sel = DivW'(div_for(115200));
            default: div_sel = DivW'(div_for(115200));
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            div_q   <= '0;
            bcnt_q  <= '0;
            s_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bcnt_q  <= bcnt_d;
            s_q     <= s_d;
            b_q     <= b_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            sync1_q <= rx.RxD;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        s_d     = s_q;
        b_d     = b_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        // Counter held at zero while idle so sampling phase follows start detection.
        bcnt_d  = (state_q == StIdle || tick) ? '0 : bcnt_q + DivW'(1);
        if (tick) s_d = s_q + 4'd1;

        unique case (state_q)
            StIdle: begin
                if (rx.Rx_EN && prev_q && !sync2_q) begin
                    state_d = StStart;
                    s_d     = '0;
                    div_d   = div_sel;
                end
            end
            StStart: begin
                if (mid && sync2_q) begin
                    state_d = StIdle;
                    s_d     = '0;
                end else if (last) begin
                    state_d = StData;
                    b_d     = '0;
                end
            end
            StData: begin
                if (mid) shift_d[b_q] = sync2_q;
                if (last) begin
                    b_d = b_q + 3'd1;
                    if (b_q == 3'd7) state_d = StParity;
                end
            end
            StParity: begin
                if (mid) par_d = sync2_q;
                if (last) state_d = StStop;
            end
            StStop: begin
                if (mid) begin
                    data_d  = shift_q;
                    perr_d  = (^shift_q) != par_q;
                    ferr_d  = !sync2_q;
                    valid_d = ((^shift_q) == par_q) && sync2_q;
                    state_d = StIdle;
                    s_d     = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Disable discards any partial frame but leaves the last result visible.
        if (!rx.Rx_EN) begin
            state_d = StIdle;
            s_d     = '0;
            b_d     = '0;
            valid_d = 1'b0;
        end
    end

    always_comb begin
        tick         = (state_q != StIdle) && (bcnt_q == div_q - DivW'(1));
        mid          = tick && (s_q == 4'd7);
        last         = tick && (s_q == 4'd15);
        rx.Rx_DATA   = data_q;
        rx.Rx_VALID  = valid_q;
        rx.Rx_PERROR = perr_q;
        rx.Rx_FERROR = ferr_q;
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 115200 baud / 50 MHz (432 clk per bit).
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int BitClk = 432;

    logic clk_tb = 1'b0;
    logic reset_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    uart_receiver_if rif ();

    uart_receiver #(.CLK_HZ(50000000)) dut (
        .clk   (clk_tb),
        .reset (reset_tb),
        .rx    (rif)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_valid;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         vcnt = 0;
    int         vcyc = 0;
    int         tstart = 0;
    logic [7:0] data_log [64];

    always @(posedge clk_tb) begin
        cyc <= cyc + 1;
        if (rif.Rx_VALID) begin
            vcnt <= vcnt + 1;
            vcyc <= cyc;
            data_log[vcnt[5:0]] <= rif.Rx_DATA;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic b, input int n);
        rif.RxD = b;
        repeat (n) @(negedge clk_tb);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic st);
        tstart = cyc;
        hold(1'b0, BitClk);
        for (int i = 0; i < 8; i++) hold(d[i], BitClk);
        hold(p, BitClk);
        hold(st, BitClk);
        rif.RxD = 1'b1;
    endtask

    task automatic check_status(input string name, input logic [7:0] d, input logic pe,
                                input logic fe);
        check({name, ".data"}, 32'(rif.Rx_DATA), 32'(d));
        check({name, ".perr"}, 32'(rif.Rx_PERROR), 32'(pe));
        check({name, ".ferr"}, 32'(rif.Rx_FERROR), 32'(fe));
    endtask

    initial begin
        int v0;
        vecs[0] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 0, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 0, 1'b0, 1'b1};
        vecs[4] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1, 1'b0, 1'b0};

        rif.baud_sel = 3'b111;
        rif.Rx_EN    = 1'b1;
        rif.RxD      = 1'b1;
        repeat (4) @(negedge clk_tb);
        check_status("reset", 8'h00, 1'b0, 1'b0);
        check("reset.valid", 32'(rif.Rx_VALID), 32'd0);
        reset_tb = 1'b1;
        repeat (20) @(negedge clk_tb);

        for (int i = 0; i < 5; i++) begin
            v0 = vcnt;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            hold(1'b1, 60);
            check_status($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr,
                         vecs[i].exp_ferr);
            check($sformatf("vec%0d.valid", i), 32'(vcnt - v0), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid == 1) begin
                check($sformatf("vec%0d.latency_ok", i),
                      32'((vcyc - tstart >= 4537) && (vcyc - tstart <= 4541)), 32'd1);
            end
        end

        // Short low pulse: rejected at start-bit midpoint.
        v0 = vcnt;
        hold(1'b0, 100);
        hold(1'b1, 500);
        check_status("glitch", 8'h3C, 1'b0, 1'b0);
        check("glitch.valid", 32'(vcnt - v0), 32'd0);

        // baud_sel wiggled mid-frame must not disturb the frame in flight.
        v0 = vcnt;
        fork
            send_frame(8'h55, 1'b0, 1'b1);
            begin
                repeat (1000) @(negedge clk_tb);
                rif.baud_sel = 3'b000;
                repeat (2000) @(negedge clk_tb);
                rif.baud_sel = 3'b111;
            end
        join
        hold(1'b1, 60);
        check_status("f55", 8'h55, 1'b0, 1'b0);
        check("f55.valid", 32'(vcnt - v0), 32'd1);

        // Enable dropped mid-data: frame discarded, previous byte retained.
        v0 = vcnt;
        fork
            send_frame(8'hF0, 1'b0, 1'b1);
            begin
                repeat (2000) @(negedge clk_tb);
                rif.Rx_EN = 1'b0;
            end
        join
        hold(1'b1, 60);
        rif.Rx_EN = 1'b1;
        hold(1'b1, 60);
        check_status("en_drop", 8'h55, 1'b0, 1'b0);
        check("en_drop.valid", 32'(vcnt - v0), 32'd0);

        // Back-to-back frames with no idle gap.
        v0 = vcnt;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b1);
        hold(1'b1, 60);
        check("b2b.count", 32'(vcnt - v0), 32'd3);
        check("b2b.byte0", 32'(data_log[v0[5:0]]), 32'h00);
        check("b2b.byte1", 32'(data_log[6'(v0 + 1)]), 32'hFF);
        check("b2b.byte2", 32'(data_log[6'(v0 + 2)]), 32'h81);
        check_status("b2b", 8'h81, 1'b0, 1'b0);

        // Leave a parity error latched, then reset mid-data.
        send_frame(8'h01, 1'b0, 1'b1);
        hold(1'b1, 60);
        check_status("pre_rst", 8'h01, 1'b1, 1'b0);
        v0 = vcnt;
        hold(1'b0, BitClk);
        hold(1'b1, 2 * BitClk);
        reset_tb = 1'b0;
        #2;
        check_status("async_rst", 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk_tb);
        reset_tb = 1'b1;
        hold(1'b1, 5000);
        check_status("post_rst", 8'h00, 1'b0, 1'b0);
        check("post_rst.valid", 32'(vcnt - v0), 32'd0);

        v0 = vcnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        hold(1'b1, 60);
        check_status("recover", 8'hA5, 1'b0, 1'b0);
        check("recover.valid", 32'(vcnt - v0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial receive stage directly downstream of the UART transmitter. It consumes the transmitter's TxD line, or an external RxD pin, and delivers parallel bytes.
- Frame format matches the transmitter: start (0), D0..D7 LSB first, even parity bit, stop (1).
- Baud rate is selected by the same 3-bit baud_sel code. A 16x oversampling tick is generated internally.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz. Used to compute the oversample divisors.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- baud_sel  input  3  baud code: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200
- Rx_EN  input  1  receiver enable; 0 forces IDLE and ignores RxD
- RxD  input  1  serial line, asynchronous to clk, idle high
- Rx_DATA  output  8  last received byte
- Rx_VALID  output  1  one-cycle pulse: good frame received
- Rx_PERROR  output  1  parity error flag for the last frame
- Rx_FERROR  output  1  framing error flag (stop bit sampled 0) for the last frame

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE, all counters 0.
  - Synchronizer flops = 1.
  - Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0.
- Baud tick generator:
  - Divisor = round(CLK_HZ/(16*baud)). At 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27.
  - The counter counts 0..divisor-1. It emits a one-clk tick at divisor-1, then wraps.
  - The counter is held at 0 while in IDLE, so sampling phase aligns to start-bit detection.
  - A baud_sel change takes effect at the next frame. The divisor is latched on leaving IDLE.
- RxD passes through a 2-flop synchronizer. All decisions use the synchronized value.
- FSM states: IDLE, START, DATA, PARITY, STOP. A 4-bit sample counter s runs 0..15 on ticks. A 3-bit bit index b tracks data bits.
  - IDLE: when Rx_EN=1 and sync RxD falls to 0, go to START with s=0.
  - START: at s=7, sample RxD.
    - If 1: glitch. Return to IDLE; no flags change, no VALID.
    - If 0: at s=15, go to DATA with b=0.
  - DATA: at s=7, shift the sample into shift[b] (LSB first). At s=15, b increments. After b=7 the FSM goes to PARITY.
  - PARITY: at s=7, capture parity bit p. At s=15, go to STOP.
  - STOP: at s=7, evaluate the frame and go to IDLE on the same tick:
    - Rx_DATA <= shift.
    - Rx_PERROR <= (^shift) != p.
    - Rx_FERROR <= (RxD==0).
    - Rx_VALID pulses 1 for one clk only if both errors are 0.
  - Returning to IDLE at mid-stop allows back-to-back frames.
- Flag lifetime:
  - Rx_DATA, Rx_PERROR and Rx_FERROR hold until the next frame's STOP evaluation. The glitch path does not update them.
  - Rx_DATA updates even on error, so the bench can inspect it.
- Rx_EN deasserted mid-frame: on the next clk, return to IDLE and discard the partial byte. Flags are unchanged.
- reset asserted mid-frame: immediate return to reset values.
- Frame latency: Rx_VALID asserts 10.5 bit periods after the start-bit falling edge, plus 2–3 clk of synchronizer/detection delay. At 115200 and 50 MHz, one bit = 16*27 = 432 clk.
- Line held low forever (break): decoded as byte 0x00 with FERROR=1. The receiver then waits in IDLE for a falling edge, which requires RxD to return to 1 first.

Test Plan:
- baud_sel=111, Rx_EN=1. Drive frame 0xFF with parity 0, stop 1 at 432 clk/bit -> Rx_VALID pulse ~4536 clk after start edge; Rx_DATA=8'hFF; PERROR=FERROR=0.
- Frame 0x01 with parity 0 (expected 1) -> Rx_DATA=8'h01, Rx_PERROR=1, Rx_VALID stays 0. Next clean frame 0xA5 with parity 0 -> PERROR clears, VALID pulses.
- Frame 0x3C with stop bit 0 -> Rx_FERROR=1, no VALID. Line returns high, then frame 0x3C with good stop -> FERROR=0, VALID=1.
- RxD low for 100 clk (<7 sample ticks at divisor 27), then high -> FSM back to IDLE, no flag or data change. A following good frame 0x55 is received correctly.
- Connect a uart_transmitter (Tx_EN=1) to RxD at baud_sel=011. Send 0x00, 0xFF, 0x81 back-to-back -> three VALID pulses in order with matching Rx_DATA, no errors.
- Mid-DATA, drop reset to 0 for 3 clk -> all outputs return to reset values at once. Mid-frame Rx_EN=0 -> no VALID for that frame, previous Rx_DATA retained.
